keypad_scan_entry: RTL
======================

// Module: keypad_scan_entry
// PURPOSE
//  Scanner for the 4x4 matrix keypad. Drives col, samples row, debounces each press and decodes
//  it to a key code. Digit keys collect into a 6-digit BCD HHMMSS entry buffer. Clock-set,
//  alarm-set and countdown-set all read the buffer, then convert it with bcd2sec.
//  Emits one key_valid pulse per debounced press and a commit pulse when an entry is accepted.
// PARAMETERS
//  CLK_HZ     100_000_000  system clock frequency
//  SCAN_HZ    1000         scan tick rate; one column dwell per tick
//  DEB_TICKS  4            consecutive identical ticks needed to accept a press or a release
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous reset, active-low
//  en         in   1   scanning enable
//  clr        in   1   synchronous buffer clear (1 clk pulse)
//  row        in   4   keypad rows, pulled up, active-low
//  col        out  4   keypad columns, one driven low at a time
//  key_valid  out  1   1-clk pulse, key_code valid
//  key_code   out  4   0-9 digit, A=0xA, B=0xB, C=0xC, D=0xD (backspace), *=0xE (clear), #=0xF (commit)
//  digits     out  24  BCD {h1,h2,m1,m2,s1,s2}; newest digit at [3:0]
//  digit_cnt  out  3   digits entered, 0..6
//  commit     out  1   1-clk pulse, entry accepted
//  entry_err  out  1   1-clk pulse, commit rejected
// BEHAVIOUR
//  Reset: col=4'hF, key_valid=0, key_code=0, digits=0, digit_cnt=0, commit=0, entry_err=0,
//   FSM=SCAN, tick counter=0, column index=0.
//  row passes through a 2-FF synchroniser; 2 clk latency. tick = 1-clk strobe every CLK_HZ/SCAN_HZ clk.
//  Keymap by row/col: r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D.
//  en=0: col=4'hF, FSM forced to SCAN, no pulses, buffer retained. clr still acts.
//  FSM, advancing only on tick:
//   SCAN: drive ~(1<<idx). If synced row is one-hot-low, latch row and go to DEBOUNCE with cnt=1.
//    Otherwise idx=idx+1 mod 4. All-high or multiple-low row = no key.
//   DEBOUNCE: column held. Same row: cnt++. At cnt==DEB_TICKS go to PRESSED.
//    Different row: back to SCAN, idx unchanged.
//   PRESSED: key_valid and key_code asserted for the single clk after the entering tick.
//    Then go to RELEASE with cnt=0.
//   RELEASE: all-high row: cnt++; any low: cnt=0. At cnt==DEB_TICKS go to SCAN, idx+1.
//  Entry handling, in the clk after key_valid:
//   Digit 0-9 with digit_cnt<6: digits={digits[19:0],key}, cnt++. At cnt==6 the digit is ignored.
//   D with cnt>0: digits={4'h0,digits[23:4]}, cnt--. At cnt==0: no-op.
//   *: digits=0, cnt=0.
//   #: if cnt==6 and h1h2<=23, m1<=5, s1<=5: commit. Otherwise entry_err. Buffer unchanged either way.
//   A/B/C: key_valid pulse only, no buffer effect.
//  clr on the same clk as an entry update: clr wins.
//  Reset mid-operation aborts any debounce. No pulse is emitted.
// CONFIGURATION
//  KEYPAD_AUTOREPEAT_EN defined:
//   In RELEASE, a key held continuously for 16*DEB_TICKS ticks re-emits key_valid with the same code.
//   It then repeats every 4*DEB_TICKS ticks and is processed as a new press.
//   # and * never repeat.
//  Undefined: exactly one key_valid per press, however long the key is held.
// TESTING  (CLK_HZ=1000, SCAN_HZ=100 -> tick every 10 clk, DEB_TICKS=3)
//  Reset -> col=4'hF, digits=0, digit_cnt=0; raise en -> col walks E,D,B,7 one per tick.
//  Press 1,2,3,0,4,5 (8 ticks each, release 8) -> digits=24'h123045, digit_cnt=6; # -> commit 1 clk.
//  Enter 2,5,0,0,0,0 then # -> entry_err 1 clk, no commit; D -> digits=24'h025000, digit_cnt=5.
//  Row bounces low/high for 2 ticks, then stable low 5 ticks -> exactly one key_valid.
//  Keys 1 and 4 held together (same column) -> no key_valid; 7th digit with cnt=6 -> ignored.
//  rst low during DEBOUNCE -> all outputs at reset values, no key_valid after release.

Source files
------------

// File: rtl/keypad_scan_entry.sv
// keypad_scan_entry: 4x4 matrix keypad scanner with debounce, key decode and a
// 6-digit BCD HHMMSS entry buffer (commit / entry_err on '#').
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (a held key re-emits its code).
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_SCAN     | walk the driven column each tick, look for a single low row
// S_DEBOUNCE | column held, count identical row samples up to DEB_TICKS
// S_PRESSED  | key accepted, key_valid pulsed; moves to S_RELEASE next tick
// S_RELEASE  | column held, count all-high row samples up to DEB_TICKS
module keypad_scan_entry #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned SCAN_HZ   = 1000,
  parameter int unsigned DEB_TICKS = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic [3:0]  row_i,
  output logic [3:0]  col_o,
  output logic        key_valid_o,
  output logic [3:0]  key_code_o,
  output logic [23:0] digits_o,
  output logic [2:0]  digit_cnt_o,
  output logic        commit_o,
  output logic        entry_err_o
);

  localparam int unsigned TICK_DIV    = CLK_HZ / SCAN_HZ;
  localparam int unsigned TW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LD   = TW'(TICK_DIV - 1);
  localparam int unsigned CW          = $clog2(DEB_TICKS + 1);
  localparam logic [CW-1:0] DEB_CNT   = CW'(DEB_TICKS);
  // nibble index = {row, col}: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D
  localparam logic [63:0] KEYMAP      = 64'hDF0E_C987_B654_A321;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RW          = $clog2(16 * DEB_TICKS);
  localparam logic [RW-1:0] RPT_FIRST = RW'(16 * DEB_TICKS - 1);
  localparam logic [RW-1:0] RPT_NEXT  = RW'(4 * DEB_TICKS - 1);
  logic [RW-1:0] rpt_q, rpt_d;
`endif

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_e;

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    row_lat_q, row_lat_d;
  logic [3:0]    row_s1_q, row_s2_q;
  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  logic          key_valid_q, kv_d;
  logic [3:0]    key_code_q, code_d;
  logic [3:0]    col_q;
  logic [3:0]    row_low;
  logic          row_one_hot;
  logic [1:0]    row_idx;
  logic [5:0]    key_bit;
  logic [3:0]    key_dec;
  logic [23:0]   digits_q;
  logic [2:0]    digit_cnt_q;
  logic          commit_q, entry_err_q;
  logic          entry_ok;

  // Scan tick divider: down-counter, strobe on terminal count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                tick_cnt_q <= '0;
    else if (tick_cnt_q == '0)  tick_cnt_q <= TICK_LD;
    else                        tick_cnt_q <= tick_cnt_q - 1'b1;
  end

  assign tick = (tick_cnt_q == '0);

  // Two-flop synchroniser on the asynchronous row inputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= row_i;
      row_s2_q <= row_s1_q;
    end
  end

  assign row_low     = ~row_s2_q;
  assign row_one_hot = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);
  assign cnt_inc     = cnt_q + 1'b1;

  // Row index of the latched one-hot-low row, used for key decode.
  always_comb begin
    row_idx = 2'd0;
    case (row_lat_q)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  assign key_bit = {row_idx, idx_q, 2'b00};
  assign key_dec = KEYMAP[key_bit +: 4];

  // Scan/debounce FSM next-state; only moves on tick, parked in S_SCAN while disabled.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    row_lat_d = row_lat_q;
    kv_d      = 1'b0;
    code_d    = key_code_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_d     = rpt_q;
`endif
    if (!en_i) begin
      state_d = S_SCAN;
      cnt_d   = '0;
    end else if (tick) begin
      case (state_q)
        S_SCAN: begin
          if (row_one_hot) begin
            row_lat_d = row_s2_q;
            cnt_d     = CW'(1);
            state_d   = S_DEBOUNCE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        S_DEBOUNCE: begin
          if (row_s2_q == row_lat_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_CNT) begin
              state_d = S_PRESSED;
              kv_d    = 1'b1;
              code_d  = key_dec;
            end
          end else begin
            state_d = S_SCAN;
          end
        end
        S_PRESSED: begin
          state_d = S_RELEASE;
          cnt_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
          rpt_d   = RPT_FIRST;
`endif
        end
        S_RELEASE: begin
          if (row_s2_q == 4'hF) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_CNT) begin
              state_d = S_SCAN;
              idx_d   = idx_q + 2'd1;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_d = RPT_FIRST;
`endif
          end else begin
            cnt_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (row_s2_q == row_lat_q) begin
              if (rpt_q == '0) begin
                rpt_d = RPT_NEXT;
                // '*' and '#' are never repeated
                if (key_code_q < 4'hE) kv_d = 1'b1;
              end else begin
                rpt_d = rpt_q - 1'b1;
              end
            end else begin
              rpt_d = RPT_FIRST;
            end
`endif
          end
        end
        default: state_d = S_SCAN;
      endcase
    end
  end

  // FSM state, column drive and key output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_SCAN;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      row_lat_q   <= 4'hF;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      col_q       <= 4'hF;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      row_lat_q   <= row_lat_d;
      key_valid_q <= kv_d;
      key_code_q  <= code_d;
      col_q       <= en_i ? ~(4'b0001 << idx_d) : 4'hF;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q       <= rpt_d;
`endif
    end
  end

  // Accept only a complete, in-range HHMMSS (digits are always BCD 0-9).
  assign entry_ok = (digit_cnt_q == 3'd6) &&
                    ((digits_q[23:20] < 4'd2) ||
                     ((digits_q[23:20] == 4'd2) && (digits_q[19:16] <= 4'd3))) &&
                    (digits_q[15:12] <= 4'd5) &&
                    (digits_q[7:4]   <= 4'd5);

  // Entry buffer update in the clock after key_valid; clr overrides.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      digits_q    <= 24'h0;
      digit_cnt_q <= 3'd0;
      commit_q    <= 1'b0;
      entry_err_q <= 1'b0;
    end else begin
      commit_q    <= 1'b0;
      entry_err_q <= 1'b0;
      if (clr_i) begin
        digits_q    <= 24'h0;
        digit_cnt_q <= 3'd0;
      end else if (key_valid_q) begin
        if (key_code_q <= 4'd9) begin
          if (digit_cnt_q < 3'd6) begin
            digits_q    <= {digits_q[19:0], key_code_q};
            digit_cnt_q <= digit_cnt_q + 3'd1;
          end
        end else begin
          case (key_code_q)
            4'hD: begin
              if (digit_cnt_q != 3'd0) begin
                digits_q    <= {4'h0, digits_q[23:4]};
                digit_cnt_q <= digit_cnt_q - 3'd1;
              end
            end
            4'hE: begin
              digits_q    <= 24'h0;
              digit_cnt_q <= 3'd0;
            end
            4'hF: begin
              if (entry_ok) commit_q    <= 1'b1;
              else          entry_err_q <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign col_o       = col_q;
  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;
  assign digits_o    = digits_q;
  assign digit_cnt_o = digit_cnt_q;
  assign commit_o    = commit_q;
  assign entry_err_o = entry_err_q;

endmodule
